// File: rtl/vga_framebuffer_scan_pkg.sv
// VGA 640x480 timing constants, framebuffer geometry and colour type.
// Pure declarations; no latency or backpressure.
package vga_pkg;

    localparam logic [9:0] H_ACTIVE     = 10'd640;
    localparam logic [9:0] H_SYNC_START = 10'd656;
    localparam logic [9:0] H_SYNC_END   = 10'd751;
    localparam logic [9:0] H_TOTAL      = 10'd800;
    localparam logic [9:0] V_ACTIVE     = 10'd480;
    localparam logic [9:0] V_SYNC_START = 10'd490;
    localparam logic [9:0] V_SYNC_END   = 10'd491;
    localparam logic [9:0] V_TOTAL      = 10'd525;

    localparam int CELL_SHIFT = 4;
    localparam int FB_COLS    = 40;
    localparam int FB_ROWS    = 30;
    localparam int FB_BITS    = FB_COLS * FB_ROWS;

    typedef logic [11:0] color_t;

    // row*40 + col without a multiplier: (row<<5) + (row<<3) + col
    function automatic logic [10:0] cell_index(input logic [4:0] row, input logic [5:0] col);
        return {1'b0, row, 5'b0} + {3'b0, row, 3'b0} + {5'b0, col};
    endfunction

endpackage

// File: rtl/vga_framebuffer_scan_timing.sv
// Pixel-enable generator, h/v scan counters, raw syncs, active flag, frame strobe.
// Counters advance on every second clock; no backpressure.
module vga_timing
    import vga_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    output logic       pix_en,
    output logic [5:0] col,
    output logic [4:0] row,
    output logic       active,
    output logic       hs_raw,
    output logic       vs_raw,
    output logic       frame_start
);

    logic       pix_en_q, pix_en_d;
    logic [9:0] h_q, h_d;
    logic [9:0] v_q, v_d;
    logic       frame_start_q, frame_start_d;

    always_comb begin
        pix_en_d = ~pix_en_q;
        h_d      = h_q;
        v_d      = v_q;
        if (pix_en_q) begin
            if (h_q == H_TOTAL - 10'd1) begin
                h_d = 10'd0;
                v_d = (v_q == V_TOTAL - 10'd1) ? 10'd0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
        end
        // Pulse on the edge where the counter lands on (0, V_ACTIVE).
        frame_start_d = pix_en_q && (h_q == H_TOTAL - 10'd1) && (v_q == V_ACTIVE - 10'd1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pix_en_q      <= 1'b0;
            h_q           <= 10'd0;
            v_q           <= 10'd0;
            frame_start_q <= 1'b0;
        end else begin
            pix_en_q      <= pix_en_d;
            h_q           <= h_d;
            v_q           <= v_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign pix_en      = pix_en_q;
    assign col         = h_q[CELL_SHIFT +: 6];
    assign row         = v_q[CELL_SHIFT +: 5];
    assign active      = (h_q < H_ACTIVE) && (v_q < V_ACTIVE);
    assign hs_raw      = !((h_q >= H_SYNC_START) && (h_q <= H_SYNC_END));
    assign vs_raw      = !((v_q >= V_SYNC_START) && (v_q <= V_SYNC_END));
    assign frame_start = frame_start_q;

endmodule

// File: rtl/vga_framebuffer_scan.sv
// 40x30 cell framebuffer to 640x480 VGA scan-out; outputs lag the counter by one pixel (2 clocks).
// No backpressure. FRAME_LATCH_EN adds a shadow copy taken on frame_start.
module vga_framebuffer_scan
    import vga_pkg::*;
#(
    parameter color_t FG_COLOR = 12'hFFF,
    parameter color_t BG_COLOR = 12'h000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [FB_BITS-1:0] framebuffer,
    output logic               vga_hs,
    output logic               vga_vs,
    output logic [3:0]         vga_r,
    output logic [3:0]         vga_g,
    output logic [3:0]         vga_b,
    output logic               frame_start
);

    logic         pix_en;
    logic [5:0]   col;
    logic [4:0]   row;
    logic         active;
    logic         hs_raw;
    logic         vs_raw;
    logic [FB_BITS-1:0] fb_src;
    logic [10:0]  cell_idx;
    logic         cell_bit;
    color_t       color_d, color_q;
    logic         hs_d, hs_q;
    logic         vs_d, vs_q;

    vga_timing u_timing (
        .clock       (clock),
        .reset       (reset),
        .pix_en      (pix_en),
        .col         (col),
        .row         (row),
        .active      (active),
        .hs_raw      (hs_raw),
        .vs_raw      (vs_raw),
        .frame_start (frame_start)
    );

`ifdef FRAME_LATCH_EN
    logic [FB_BITS-1:0] shadow_q, shadow_d;

    always_comb begin
        shadow_d = shadow_q;
        if (frame_start) shadow_d = framebuffer;
    end

    always_ff @(posedge clock) begin
        if (reset) shadow_q <= '0;
        else       shadow_q <= shadow_d;
    end

    assign fb_src = shadow_q;
`else
    assign fb_src = framebuffer;
`endif

    // Index is parked at 0 in blanking so the lookup never leaves the 1200-bit range.
    assign cell_idx = active ? cell_index(row, col) : 11'd0;
    assign cell_bit = active & fb_src[cell_idx];

    always_comb begin
        color_d = color_q;
        hs_d    = hs_q;
        vs_d    = vs_q;
        if (pix_en) begin
            hs_d    = hs_raw;
            vs_d    = vs_raw;
            color_d = !active ? 12'h000 : (cell_bit ? FG_COLOR : BG_COLOR);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            color_q <= 12'h000;
        end else begin
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            color_q <= color_d;
        end
    end

    assign vga_hs = hs_q;
    assign vga_vs = vs_q;
    assign vga_r  = color_q[11:8];
    assign vga_g  = color_q[7:4];
    assign vga_b  = color_q[3:0];

endmodule

// File: tb/tb_vga_framebuffer_scan.sv
// Scoreboard bench: stimulus pushes the expected output vector per clock, monitor pops after each edge.
module tb_vga_framebuffer_scan;

    localparam logic [11:0] FG = 12'hFFF;
    localparam logic [11:0] BG = 12'h00A;
    localparam logic [17:0] RST_VAL = {1'b0, 1'b1, 1'b1, 12'h000};

    logic          clock = 1'b0;
    logic          reset;
    logic [1199:0] fb;
    logic          vga_hs, vga_vs, frame_start;
    logic [3:0]    vga_r, vga_g, vga_b;

    int checks   = 0;
    int failures = 0;
    int t        = 0;
    bit done     = 0;
    logic [17:0] exp_q[$];
`ifdef FRAME_LATCH_EN
    logic [1199:0] shadow = '0;
    logic          prev_fs = 1'b0;
`endif

    always #5 clock = ~clock;

    vga_framebuffer_scan #(.FG_COLOR(FG), .BG_COLOR(BG)) dut (
        .clock       (clock),
        .reset       (reset),
        .framebuffer (fb),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .frame_start (frame_start)
    );

    // Output after edge tn (edges counted from the last edge with reset high).
    // Edge 2k+2 shows pixel k; the counter value after edge 2j is j.
    function automatic logic [17:0] expect_out(input int tn, input logic [1199:0] src);
        int k, h, v, idx;
        logic hs, vs, fs, act;
        logic [11:0] c;
        if (tn < 2) return RST_VAL;
        k   = (tn - 2) / 2;
        h   = k % 800;
        v   = (k / 800) % 525;
        hs  = !(h >= 656 && h <= 751);
        vs  = !(v >= 490 && v <= 491);
        act = (h < 640) && (v < 480);
        c   = 12'h000;
        if (act) begin
            idx = (v / 16) * 40 + (h / 16);
            c   = src[idx] ? FG : BG;
        end
        fs = (tn % 2 == 0) && (((tn / 2) % 420000) == 384000);
        return {fs, hs, vs, c};
    endfunction

    task automatic step();
        int tn;
        logic [17:0] e;
        logic [1199:0] src;
        tn = reset ? 0 : t + 1;
`ifdef FRAME_LATCH_EN
        src = shadow;
`else
        src = fb;
`endif
        e = reset ? RST_VAL : expect_out(tn, src);
`ifdef FRAME_LATCH_EN
        if (reset)        shadow = '0;
        else if (prev_fs) shadow = fb;
        prev_fs = e[17];
`endif
        exp_q.push_back(e);
        t = tn;
        @(negedge clock);
    endtask

    // Step until the next edge is the first one to show pixel (h, v).
    task automatic run_to(input int h, input int v);
        int n;
        n = 0;
        while (!((t + 1) >= 2 && ((t + 1) % 2 == 0) && ((t - 1) / 2 == v * 800 + h))) begin
            step();
            n++;
            if (n > 100000) begin
                failures++;
                $display("FAIL run_to h=%0d v=%0d not reached, t=%0d", h, v, t);
                return;
            end
        end
    endtask

    initial begin : monitor
        logic [17:0] got, want;
        forever begin
            @(posedge clock);
            #1;
            if (done) break;
            got = {frame_start, vga_hs, vga_vs, vga_r, vga_g, vga_b};
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_empty t=%0d got=%h", t, got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    failures++;
                    $display("FAIL out t=%0d {fs,hs,vs,rgb} got=%h want=%h", t, got, want);
                end
            end
        end
    end

    initial begin : stimulus
        reset = 1'b1;
        fb    = '0;
        fb[0] = 1'b1;
        repeat (5) step();
        reset = 1'b0;
        run_to(0, 10);
        fb[41] = 1'b1;
        run_to(0, 32);
        fb = '1;
        run_to(400, 34);
        reset = 1'b1;
        step();
        reset = 1'b0;
        fb     = '0;
        fb[39] = 1'b1;
        fb[40] = 1'b1;
        run_to(100, 16);
        step();
        step();
        done = 1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
